// File: rtl/vmask_pkg.sv
// Shared encodings, FSM state type and constants for the vector mask
// reduction sequencer (vcpop.m / vfirst.m).
package vmask_pkg;

  localparam logic VMASK_CPOP  = 1'b0;
  localparam logic VMASK_FIRST = 1'b1;

  localparam int POPCNT_LAT = 3;

  // Wide enough for any DATA_WIDTH; users slice the low bits.
  localparam int                      NONE_FOUND_W = 1024;
  localparam logic [NONE_FOUND_W-1:0] NONE_FOUND   = {NONE_FOUND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } vmask_state_t;

endpackage

// File: rtl/vmask_popcnt_pipe.sv
// Three-stage registered popcount of one mask beat: quarter counts,
// half sums, then the full beat count.
module vmask_popcnt_pipe #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_beat,
  output logic                        out_valid,
  output logic [$clog2(DATA_WIDTH):0] out_count
);
  localparam int QW  = DATA_WIDTH / 4;
  localparam int QCW = $clog2(QW) + 1;
  localparam int HCW = QCW + 1;

  function automatic logic [QCW-1:0] pop_quarter(input logic [QW-1:0] v);
    logic [QCW-1:0] c;
    c = {QCW{1'b0}};
    for (int i = 0; i < QW; i++) begin
      c = c + {{(QCW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [3:0][QCW-1:0] q_r;
  logic [1:0][HCW-1:0] h_r;
  logic                v1_r;
  logic                v2_r;

  // Adder-tree stages with a valid bit travelling alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r       <= '0;
      h_r       <= '0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      v1_r      <= in_valid;
      for (int k = 0; k < 4; k++) begin
        q_r[k] <= pop_quarter(in_beat[k*QW +: QW]);
      end
      v2_r      <= v1_r;
      h_r[0]    <= {1'b0, q_r[0]} + {1'b0, q_r[1]};
      h_r[1]    <= {1'b0, q_r[2]} + {1'b0, q_r[3]};
      out_valid <= v2_r;
      out_count <= {1'b0, h_r[0]} + {1'b0, h_r[1]};
    end
  end

endmodule

// File: rtl/vmask_reduce_seq.sv
// Mask reduction sequencer: streams mask beats from the VRF, counts set bits
// or locates the first one, and hands a scalar result to writeback.
module vmask_reduce_seq
  import vmask_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int VL_WIDTH   = 11,
  parameter int BEAT_IDX_W = VL_WIDTH - $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [VL_WIDTH-1:0]   req_vl,
  output logic                  rd_en,
  output logic [BEAT_IDX_W-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data
);
  localparam int LOG_DW = $clog2(DATA_WIDTH);
  localparam int POS_W  = BEAT_IDX_W + LOG_DW;
  localparam logic [DATA_WIDTH-1:0] RESULT_NONE = NONE_FOUND[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] RESULT_ZERO = {DATA_WIDTH{1'b0}};

  vmask_state_t              state_r, state_nxt_s;
  logic                      op_r;
  logic [LOG_DW-1:0]         rem_r;
  logic [BEAT_IDX_W-1:0]     last_idx_r;
  logic                      req_ready_r, rd_en_r, resp_valid_r;
  logic [BEAT_IDX_W-1:0]     rd_addr_r, rd_addr_nxt_s;
  logic [DATA_WIDTH-1:0]     resp_data_r, resp_data_nxt_s, result_s;
  logic                      accept_s;
  logic [LOG_DW-1:0]         req_rem_s;
  logic [BEAT_IDX_W-1:0]     req_nbeats_s;
  logic                      pend_r, pend_last_r;
  logic [BEAT_IDX_W-1:0]     pend_idx_r;
  logic [DATA_WIDTH-1:0]     tail_mask_s, beat_s;
  logic                      enc_found_s;
  logic [LOG_DW-1:0]         enc_bit_s;
  logic [POPCNT_LAT-1:0]     dl_found_r, dl_last_r;
  logic [POPCNT_LAT-1:0][POS_W-1:0] dl_pos_r;
  logic                      pc_valid_s;
  logic [LOG_DW:0]           pc_count_s;
  logic [DATA_WIDTH-1:0]     acc_r, acc_sum_s;
  logic                      first_found_r, first_found_s, last_done_s;
  logic [POS_W-1:0]          first_pos_r, first_pos_s;

  assign req_ready  = req_ready_r;
  assign rd_en      = rd_en_r;
  assign rd_addr    = rd_addr_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

  assign accept_s     = req_valid & req_ready_r;
  assign req_rem_s    = req_vl[LOG_DW-1:0];
  assign req_nbeats_s = {1'b0, req_vl[VL_WIDTH-1:LOG_DW]}
                      + {{(BEAT_IDX_W-1){1'b0}}, (req_rem_s != {LOG_DW{1'b0}})};

  // Latch the operation and tail geometry when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r       <= VMASK_CPOP;
      rem_r      <= {LOG_DW{1'b0}};
      last_idx_r <= {BEAT_IDX_W{1'b0}};
    end else if (accept_s) begin
      op_r       <= req_op;
      rem_r      <= req_rem_s;
      last_idx_r <= req_nbeats_s - BEAT_IDX_W'(1);
    end
  end

  // Tag each returned beat with the read issued one cycle earlier; data
  // without a matching read stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r      <= 1'b0;
      pend_idx_r  <= {BEAT_IDX_W{1'b0}};
      pend_last_r <= 1'b0;
    end else begin
      pend_r      <= rd_en_r;
      pend_idx_r  <= rd_addr_r;
      pend_last_r <= rd_en_r & (rd_addr_r == last_idx_r);
    end
  end

  // Tail masking of the final beat, then a lowest-bit-wins priority encoder.
  always_comb begin
    tail_mask_s = {DATA_WIDTH{1'b1}};
    if (pend_last_r && (rem_r != {LOG_DW{1'b0}})) begin
      tail_mask_s = ~({DATA_WIDTH{1'b1}} << rem_r);
    end else begin
      tail_mask_s = {DATA_WIDTH{1'b1}};
    end
    beat_s    = pend_r ? (rd_data & tail_mask_s) : {DATA_WIDTH{1'b0}};
    enc_bit_s = {LOG_DW{1'b0}};
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      enc_bit_s = beat_s[i] ? LOG_DW'(i) : enc_bit_s;
    end
    enc_found_s = |beat_s;
  end

  // Encoder results ride a delay line matching the popcount latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_found_r <= '0;
      dl_last_r  <= '0;
      dl_pos_r   <= '0;
    end else begin
      dl_found_r <= {dl_found_r[POPCNT_LAT-2:0], enc_found_s};
      dl_last_r  <= {dl_last_r[POPCNT_LAT-2:0], pend_last_r};
      dl_pos_r   <= {dl_pos_r[POPCNT_LAT-2:0], {pend_idx_r, enc_bit_s}};
    end
  end

  vmask_popcnt_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_popcnt (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pend_r),
    .in_beat   (beat_s),
    .out_valid (pc_valid_s),
    .out_count (pc_count_s)
  );

  assign acc_sum_s     = acc_r + DATA_WIDTH'(pc_count_s);
  assign first_found_s = first_found_r | dl_found_r[POPCNT_LAT-1];
  assign first_pos_s   = first_found_r ? first_pos_r : dl_pos_r[POPCNT_LAT-1];
  assign last_done_s   = pc_valid_s & dl_last_r[POPCNT_LAT-1];
  assign result_s      = (op_r == VMASK_FIRST)
                       ? (first_found_s ? DATA_WIDTH'(first_pos_s) : RESULT_NONE)
                       : acc_sum_s;

  // Count and first-index accumulators, cleared on each new request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r         <= {DATA_WIDTH{1'b0}};
      first_found_r <= 1'b0;
      first_pos_r   <= {POS_W{1'b0}};
    end else if (accept_s) begin
      acc_r         <= {DATA_WIDTH{1'b0}};
      first_found_r <= 1'b0;
      first_pos_r   <= {POS_W{1'b0}};
    end else if (pc_valid_s) begin
      acc_r         <= acc_sum_s;
      first_found_r <= first_found_s;
      first_pos_r   <= first_pos_s;
    end
  end

  // Next-state, read address and result selection.
  always_comb begin
    state_nxt_s     = state_r;
    rd_addr_nxt_s   = {BEAT_IDX_W{1'b0}};
    resp_data_nxt_s = resp_data_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (req_vl == {VL_WIDTH{1'b0}})) begin
          state_nxt_s     = ST_RESP;
          resp_data_nxt_s = (req_op == VMASK_FIRST) ? RESULT_NONE : RESULT_ZERO;
        end else if (accept_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_r == last_idx_r) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s   = ST_ISSUE;
          rd_addr_nxt_s = rd_addr_r + BEAT_IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (last_done_s) begin
          state_nxt_s     = ST_RESP;
          resp_data_nxt_s = result_s;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s     = ST_IDLE;
          resp_data_nxt_s = RESULT_ZERO;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        resp_data_nxt_s = RESULT_ZERO;
      end
    endcase
  end

  // State register and registered handshake/read outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      rd_en_r      <= 1'b0;
      rd_addr_r    <= {BEAT_IDX_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= RESULT_ZERO;
    end else begin
      state_r      <= state_nxt_s;
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      rd_en_r      <= (state_nxt_s == ST_ISSUE);
      rd_addr_r    <= rd_addr_nxt_s;
      resp_valid_r <= (state_nxt_s == ST_RESP);
      resp_data_r  <= resp_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_vmask_reduce_seq.sv
// Scoreboard bench for vmask_reduce_seq: directed requests push expected
// results; a negedge monitor checks data, latency and read count.
module tb_vmask_reduce_seq;
  localparam int DW  = 64;
  localparam int VLW = 11;
  localparam int BIW = VLW - $clog2(DW) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_op = 1'b0;
  logic [VLW-1:0] req_vl = '0;
  logic           rd_en;
  logic [BIW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [DW-1:0]  resp_data;

  typedef struct {
    logic [DW-1:0] data;
    int            lat;
    int            acc;
    int            nb;
    int            rd0;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [32];
  int            cyc = 0;
  int            rd_total = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            last_acc_cyc = 0;
  int            hs_cyc = 0;

  vmask_reduce_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_vl(req_vl), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: data one cycle after rd_en, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {$urandom, $urandom};

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  task automatic issue(input logic op, input logic [VLW-1:0] vl, input logic [DW-1:0] exp,
                       input int lat, input int nb, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_vl    = vl;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      fail_msg("accept_timeout");
    end else begin
      last_acc_cyc = cyc;
      if (push) begin
        e.data = exp; e.lat = lat; e.acc = cyc; e.nb = nb; e.rd0 = rd_total;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(req_ready && exp_q.size() == 0 && !resp_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_msg("idle_timeout");
  endtask

  // Monitor: latency and read count on the rising edge of resp_valid,
  // data on each handshake.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && resp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q[0];
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("rd_count", 64'(rd_total - e.rd0), 64'(e.nb));
        end
      end
      if (rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_handshake", 64'(resp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
        end
      end
      if (rd_en) rd_total++;
      prev_v = resp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_rd_addr", 64'(rd_addr), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
    rst = 1'b1;

    // cpop, single full beat
    wait_idle();
    mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1'b0, 11'd64, 64'd64, 6, 1, 1'b1);

    // cpop with 6-bit tail
    wait_idle();
    mem[0] = 64'h0000_0000_0000_00FF;
    mem[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1'b0, 11'd70, 64'd14, 7, 2, 1'b1);

    // cpop, two full beats, no tail masking
    wait_idle();
    mem[0] = 64'hF0F0_F0F0_F0F0_F0F0;
    mem[1] = 64'h0000_0000_0000_0001;
    issue(1'b0, 11'd128, 64'd33, 7, 2, 1'b1);

    // vfirst across four beats
    wait_idle();
    mem[0] = 64'h0; mem[1] = 64'h0;
    mem[2] = 64'h0000_0000_0000_0020;
    mem[3] = 64'h0000_0000_0000_0001;
    issue(1'b1, 11'd200, 64'd133, 9, 4, 1'b1);

    // vfirst, only bits beyond the tail are set
    wait_idle();
    mem[2] = 64'h0;
    mem[3] = 64'hFFFF_FFFF_FFFF_FF00;
    issue(1'b1, 11'd200, 64'hFFFF_FFFF_FFFF_FFFF, 9, 4, 1'b1);

    // vfirst, highest bit of a full beat
    wait_idle();
    mem[0] = 64'h8000_0000_0000_0000;
    issue(1'b1, 11'd64, 64'd63, 6, 1, 1'b1);

    // vfirst, second beat set only above the 6-bit tail
    wait_idle();
    mem[0] = 64'h0;
    mem[1] = 64'hFFFF_FFFF_FFFF_FFC0;
    issue(1'b1, 11'd70, 64'hFFFF_FFFF_FFFF_FFFF, 7, 2, 1'b1);

    // vl = 0 for both ops
    wait_idle();
    issue(1'b0, 11'd0, 64'd0, 1, 0, 1'b1);
    wait_idle();
    issue(1'b1, 11'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b1);

    // Backpressure with a second request waiting
    wait_idle();
    mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    resp_ready = 1'b0;
    fork
      begin
        issue(1'b0, 11'd64, 64'd64, 6, 1, 1'b1);
        issue(1'b1, 11'd64, 64'd0, 6, 1, 1'b1);
      end
      begin
        logic [DW-1:0] held;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!resp_valid && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        if (!resp_valid) fail_msg("bp_resp_timeout");
        held = resp_data;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_data_stable", resp_data, held);
          chk("bp_valid_held", 64'(resp_valid), 64'(1));
          chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
      end
    join
    chk("bp_accept_gap", 64'(last_acc_cyc - hs_cyc), 64'(1));

    // Reset in the middle of a 16-beat cpop
    wait_idle();
    for (int i = 0; i < 16; i++) mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1'b0, 11'd1024, 64'd0, 0, 16, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_rd_en", 64'(rd_en), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("midrst_rd_en", 64'(rd_en), 64'(0));
    chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(1));
    chk("midrst_rd_addr", 64'(rd_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_idle();
    mem[0] = 64'h0000_0000_0000_FF0F;
    issue(1'b0, 11'd8, 64'd4, 6, 1, 1'b1);

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
